// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX->MEM pipeline boundary with a 2-entry skid buffer so that
//               in_ready_o is a pure flop output. Optional M-entry forwarding
//               port enabled by macro EX_MEM_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int REG_AW   = 5,
    parameter int CSR_AW   = 12,
    parameter int MEMOP_W  = 4,
    parameter int TRAP_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic [XLEN-1:0]     pc_ex_mem_i,
    output logic [XLEN-1:0]     pc_ex_mem_o,
    input  logic [INST_LEN-1:0] inst_ex_mem_i,
    output logic [INST_LEN-1:0] inst_ex_mem_o,
    input  logic [REG_AW-1:0]   rd_idx_ex_mem_i,
    output logic [REG_AW-1:0]   rd_idx_ex_mem_o,
    input  logic                rd_wen_ex_mem_i,
    output logic                rd_wen_ex_mem_o,
    input  logic [XLEN-1:0]     alu_res_ex_mem_i,
    output logic [XLEN-1:0]     alu_res_ex_mem_o,
    input  logic [XLEN-1:0]     st_data_ex_mem_i,
    output logic [XLEN-1:0]     st_data_ex_mem_o,
    input  logic [MEMOP_W-1:0]  mem_op_ex_mem_i,
    output logic [MEMOP_W-1:0]  mem_op_ex_mem_o,
    input  logic [CSR_AW-1:0]   csr_idx_ex_mem_i,
    output logic [CSR_AW-1:0]   csr_idx_ex_mem_o,
    input  logic [XLEN-1:0]     csr_wdata_ex_mem_i,
    output logic [XLEN-1:0]     csr_wdata_ex_mem_o,
    input  logic                csr_wen_ex_mem_i,
    output logic                csr_wen_ex_mem_o,
    input  logic [TRAP_W-1:0]   trap_bus_ex_mem_i,
    output logic [TRAP_W-1:0]   trap_bus_ex_mem_o,
    output logic                fwd_valid_o,
    output logic [REG_AW-1:0]   fwd_rd_idx_o,
    output logic [XLEN-1:0]     fwd_data_o
);

    localparam int c_PW = 4*XLEN + INST_LEN + REG_AW + 1 + MEMOP_W + CSR_AW + 1 + TRAP_W;

    // Bit offsets of the side-effect fields that a flush must neutralise.
    localparam int c_OFF_CSR_WEN   = TRAP_W;
    localparam int c_OFF_CSR_WDATA = c_OFF_CSR_WEN + 1;
    localparam int c_OFF_CSR_IDX   = c_OFF_CSR_WDATA + XLEN;
    localparam int c_OFF_MEM_OP    = c_OFF_CSR_IDX + CSR_AW;
    localparam int c_OFF_ST_DATA   = c_OFF_MEM_OP + MEMOP_W;
    localparam int c_OFF_ALU_RES   = c_OFF_ST_DATA + XLEN;
    localparam int c_OFF_RD_WEN    = c_OFF_ALU_RES + XLEN;

    logic [c_PW-1:0] w_in_pl;
    logic [c_PW-1:0] r_m_pl;
    logic [c_PW-1:0] r_s_pl;
    logic            r_m_v;
    logic            r_s_v;
    logic            r_in_ready;
    logic            w_acc;
    logic            w_pop;

    assign w_in_pl = {pc_ex_mem_i, inst_ex_mem_i, rd_idx_ex_mem_i, rd_wen_ex_mem_i,
                      alu_res_ex_mem_i, st_data_ex_mem_i, mem_op_ex_mem_i,
                      csr_idx_ex_mem_i, csr_wdata_ex_mem_i, csr_wen_ex_mem_i,
                      trap_bus_ex_mem_i};

    assign {pc_ex_mem_o, inst_ex_mem_o, rd_idx_ex_mem_o, rd_wen_ex_mem_o,
            alu_res_ex_mem_o, st_data_ex_mem_o, mem_op_ex_mem_o,
            csr_idx_ex_mem_o, csr_wdata_ex_mem_o, csr_wen_ex_mem_o,
            trap_bus_ex_mem_o} = r_m_pl;

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_m_v;
    assign w_acc       = in_valid_i & r_in_ready;
    assign w_pop       = r_m_v & out_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_v      <= 1'b0;
            r_s_v      <= 1'b0;
            r_in_ready <= 1'b1;
            r_m_pl     <= '0;
            r_s_pl     <= '0;
        end else if (flush_i) begin
            r_m_v                                <= 1'b0;
            r_s_v                                <= 1'b0;
            r_in_ready                           <= 1'b1;
            r_m_pl[c_OFF_CSR_WEN]                <= 1'b0;
            r_m_pl[c_OFF_RD_WEN]                 <= 1'b0;
            r_m_pl[c_OFF_MEM_OP +: MEMOP_W]      <= '0;
        end else if (!r_m_v) begin
            if (w_acc) begin
                r_m_pl <= w_in_pl;
                r_m_v  <= 1'b1;
            end
        end else if (!r_s_v) begin
            if (w_acc && w_pop) begin
                r_m_pl <= w_in_pl;
            end else if (w_acc) begin
                r_s_pl     <= w_in_pl;
                r_s_v      <= 1'b1;
                r_in_ready <= 1'b0;
            end else if (w_pop) begin
                r_m_v <= 1'b0;
            end
        end else if (w_pop) begin
            // Skid entry drains into M; ordering stays FIFO.
            r_m_pl     <= r_s_pl;
            r_s_v      <= 1'b0;
            r_in_ready <= 1'b1;
        end
    end

`ifdef EX_MEM_FWD_EN
    assign fwd_valid_o  = r_m_v & rd_wen_ex_mem_o & (rd_idx_ex_mem_o != '0);
    assign fwd_rd_idx_o = rd_idx_ex_mem_o;
    assign fwd_data_o   = alu_res_ex_mem_o;
`else
    assign fwd_valid_o  = 1'b0;
    assign fwd_rd_idx_o = '0;
    assign fwd_data_o   = '0;
`endif

endmodule
`default_nettype wire
